// File: rtl/p2s_pkg.sv
// Shared types and constants for the parallel-to-serial scheduler.
package p2s_pkg;

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

   localparam int unsigned DW_DEFAULT = 8;
   localparam int unsigned WDOG_SLACK = 2;

endpackage

// File: rtl/p2s_scheduler_rr_arbiter.sv
// Combinational round-robin winner search starting at a rotating pointer.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  grant,
   output logic            valid
);

   logic [IDW-1:0] cand;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = IDW'((32'(ptr) + i) % NREQ);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            grant = cand;
         end
      end
   end

endmodule

// File: rtl/p2s_scheduler.sv
// Round-robin sharing of one parallel-to-serial serializer between NREQ requesters,
// with an idle gap between frames and a watchdog on the serializer's end pulse.
module p2s_scheduler
   import p2s_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = DW_DEFAULT,
   parameter int unsigned GAP  = 1,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] data,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      ser_a,
   output logic               ser_bgn,
   input  logic               ser_end,
   output logic               busy,
   output logic [IDW-1:0]     cur_id,
   output logic               timeout
);

   localparam int unsigned WDOG_MAX = DW + WDOG_SLACK;
   localparam int unsigned WW       = $clog2(WDOG_MAX + 1);

   state_t         state;
   state_t         exit_state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant;
   logic           grant_vld;
   logic [WW-1:0]  wdog;
   logic [3:0]     gap_cnt;
   logic [DW-1:0]  words [NREQ];

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant),
      .valid (grant_vld)
   );

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         words[i] = data[i*DW +: DW];
      end
   end

   // With no gap configured a finished frame returns straight to idle.
   assign exit_state = (GAP == 0) ? StIdle : StGap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= StIdle;
         ack     <= '0;
         ser_a   <= '0;
         ser_bgn <= 1'b0;
         busy    <= 1'b0;
         cur_id  <= '0;
         timeout <= 1'b0;
         rr_ptr  <= '0;
         wdog    <= '0;
         gap_cnt <= '0;
      end else begin
         ack     <= '0;
         ser_bgn <= 1'b0;
         timeout <= 1'b0;
         unique case (state)
            StIdle: begin
               if (grant_vld) begin
                  cur_id     <= grant;
                  ser_a      <= words[grant];
                  ack[grant] <= 1'b1;
                  ser_bgn    <= 1'b1;
                  busy       <= 1'b1;
                  rr_ptr     <= (32'(grant) == NREQ - 1) ? '0 : grant + IDW'(1);
                  wdog       <= '0;
                  state      <= StShift;
               end
            end
            StShift: begin
               wdog <= wdog + WW'(1);
               // wdog counts SHIFT cycles; the watchdog fires as it reaches WDOG_MAX,
               // unless the end pulse lands in that same cycle.
               if (ser_end || (32'(wdog) + 1 == WDOG_MAX)) begin
                  timeout <= !ser_end;
                  gap_cnt <= '0;
                  busy    <= (GAP != 0);
                  state   <= exit_state;
               end
            end
            StGap: begin
               gap_cnt <= gap_cnt + 4'd1;
               if (32'(gap_cnt) + 1 == GAP) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/p2s_scheduler.md
Name: p2s_scheduler

Overview:
- Shares one parallel-to-serial serializer between NREQ requesters.
- Requesters are selected by round-robin arbitration. The block captures the winner's word, launches the serializer with a one-cycle begin pulse, and waits for its end-of-frame pulse.
- A programmable idle gap is inserted between frames.
- A watchdog aborts a frame if the serializer never signals completion.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, parallel word width; the serializer emits DW bits per frame.
- GAP, 1, idle cycles inserted after each frame (0..15).
- IDW, $clog2(NREQ), width of requester index.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- req, in, NREQ, request per requester; held high with data stable until ack.
- data, in, NREQ*DW, packed words; requester i occupies bits [i*DW +: DW].
- ack, out, NREQ, one-cycle pulse to the requester whose word was captured.
- ser_a, out, DW, word presented to the serializer; held stable for the whole frame.
- ser_bgn, out, 1, one-cycle serializer start pulse.
- ser_end, in, 1, serializer end pulse, coincident with the last serial bit.
- busy, out, 1, high from capture until return to IDLE.
- cur_id, out, IDW, index of the requester being served; holds its value after the frame.
- timeout, out, 1, one-cycle pulse when the watchdog aborts a frame.

Behaviour:
- Reset values (rst=1 at a clk edge): ack=0, ser_a=0, ser_bgn=0, busy=0, cur_id=0, timeout=0, rr pointer=0, state=IDLE, counters=0. Reset mid-frame aborts immediately; no ack, end or timeout follows.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If any req is high, the winner is the first requester with req high, searching from the rr pointer upward with wrap.
  - At that edge: cur_id<=winner, ser_a<=data[winner], ack[winner]<=1, ser_bgn<=1, busy<=1, rr pointer<=winner+1 mod NREQ, wdog<=0; go to SHIFT.
  - If no req is high, stay in IDLE; outputs are unchanged except the pulses, which are 0.
- SHIFT:
  - ack and ser_bgn are high only in the first SHIFT cycle.
  - wdog increments each cycle.
  - ser_end=1: go to GAP, or to IDLE if GAP=0.
  - Else if wdog==DW+2: timeout<=1, then the same exit path.
  - ser_end and the timeout condition in the same cycle: ser_end wins, no timeout.
- GAP:
  - Counts GAP cycles, then goes to IDLE.
  - busy stays high through GAP and drops on entry to IDLE.
  - req is ignored in SHIFT and GAP.
- Latency:
  - req seen in IDLE at edge t: ack and ser_bgn are high in cycle t+1.
  - Serializer delivers bits t+1..t+DW; ser_end arrives in cycle t+DW.
  - Back-to-back frames start every DW+GAP+1 cycles.
- Fairness: no requester waits more than NREQ-1 frames while holding req.
- Withdrawal: a req dropped before ack is simply not granted; nothing is latched.
- A req held after ack is treated as a new request (a requester drops req on the cycle after ack).
- ser_a and cur_id hold their values after a frame until the next capture.

Decomposition:
- Package p2s_pkg holds:
  - state enum {IDLE, SHIFT, GAP};
  - default DW constant;
  - watchdog margin constant WDOG_SLACK=2.
- One sub-module, rr_arbiter: combinational winner search from a pointer, parameterised by NREQ, outputs grant index and valid.
- The FSM, counters and output registers stay in p2s_scheduler.

Test Plan:
- Single request, NREQ=4, DW=8, GAP=1: req[2]=1 with data[2]=8'hD3, paired with a behavioural serializer (LSB first) → ack[2] and ser_bgn pulse together one cycle after req, cur_id=2; captured serial stream equals 8'hD3; ser_end after 8 bits; busy falls 2 cycles after ser_end.
- All four requesting continuously with words 8'h11/22/33/44 → grant order 0,1,2,3,0 with pointer wrap; frame starts spaced exactly 10 cycles apart.
- Serializer model suppresses ser_end → timeout pulses once after 10 SHIFT cycles, no ack is reissued, FSM returns to IDLE; next req[1]=1 is served normally.
- ser_end arriving in the same cycle the watchdog reaches 10 → no timeout pulse; normal completion.
- rst=1 during cycle 4 of a frame, then released → all outputs 0 the next cycle; no ser_end or timeout reaction; pending req[3] is granted first after reset, with pointer restarted at 0 and only req[3] high.
- GAP=0 with req[0] held → frames start back to back every 9 cycles; ser_bgn is never high in the same cycle as ser_end.
